mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that drives the ALU operation select and all datapath enables for the MIPS-subset core.
- Acts as the initiator side of the ALU interface: it generates ALUctr (ADD=2'b00, SUB=2'b01, OR=2'b10) and the operand-select fields for busA/busB, one state per cycle.
- Consumes the instruction opcode/funct fields from the IR and the datapath zero flag.
- Sits between the IR and the PC/register-file/memory/ALU datapath.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Interface: one clock; reset is synchronous and active-high.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- alu_zero  in  1  datapath flag, 1 when Alu_out==32'h0.
- PCWr  out  1  PC write enable.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWr  out  1  IR write enable.
- MemWr  out  1  data memory write enable.
- RegWr  out  1  register file write enable.
- RegDst  out  1  write register select: 0=rt, 1=rd.
- MemtoReg  out  1  busW select: 0=ALUOut, 1=MDR.
- ExtOp  out  1  immediate extend: 0=zero-extend, 1=sign-extend.
- ALUSrcA  out  1  busA select: 0=PC, 1=reg A.
- ALUSrcB  out  2  busB select: 00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2.
- ALUctr  out  2  ALU operation select.
- PCSrc  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- instr_done  out  1  one-cycle pulse in the last state of each instruction.
- instr_cnt  out  CNT_W  retired-instruction count.
- state  out  4  current state, for debug.

Behaviour:
- State register is 4 bits. Outputs are combinational decodes of state, except instr_cnt and alu_op_q, which are registered.
- On rst, next edge: state=FETCH(0), instr_cnt=0, alu_op_q=ADD.
- While rst is high, outputs show the FETCH decode: PCWr=1, IRWr=1, ALUSrcB=01, ALUctr=00, all other outputs 0.
- Decoded instructions:
  - addu: op=0, funct=6'h21.
  - subu: op=0, funct=6'h23.
  - ori: 6'h0D.
  - lw: 6'h23.
  - sw: 6'h2B.
  - beq: 6'h04.
  - j: 6'h02.
- States, their outputs and next state (unlisted outputs are 0; ALUctr defaults to ADD):
  - FETCH(0): IRWr=1, PCWr=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00. Next: DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ExtOp=1, ADD (branch target to ALUOut). Latches alu_op_q (SUB for subu, else ADD). Next by op:
    - lw/sw: MEMADR.
    - R-type addu/subu: EXEC_R.
    - ori: ORI_EX.
    - beq: BRANCH.
    - j: JUMP.
    - anything else: FETCH, with illegal=1 and instr_done=1 this cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ExtOp=1, ADD. Next: lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegWr=1, RegDst=0, MemtoReg=1, instr_done=1. Next: FETCH.
  - MEMWR(5): IorD=1, MemWr=1, instr_done=1. Next: FETCH.
  - EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUctr=alu_op_q. Next: RWB.
  - RWB(7): RegWr=1, RegDst=1, MemtoReg=0, instr_done=1. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCWr=alu_zero, instr_done=1. Next: FETCH.
  - JUMP(9): PCWr=1, PCSrc=10, instr_done=1. Next: FETCH.
  - ORI_EX(10): ALUSrcA=1, ALUSrcB=10, ExtOp=0, OR. Next: ORI_WB.
  - ORI_WB(11): RegWr=1, RegDst=0, MemtoReg=0, instr_done=1. Next: FETCH.
- Unused encodings 12–15 decode as FETCH outputs with illegal=1, and go to FETCH next.
- ALUctr=2'b11 is never driven.
- At most one of RegWr/MemWr is high in any cycle.
- op/funct are sampled only in DECODE and MEMADR. IR is stable after FETCH, so no other sampling is needed.
- instr_cnt increments by 1 on every cycle with instr_done=1, including illegal instructions. It wraps modulo 2^CNT_W.
- Latency in cycles, FETCH to FETCH:
  - lw: 5.
  - sw: 4.
  - R-type: 4.
  - ori: 4.
  - beq: 3.
  - j: 3.
  - illegal: 2.
- Reset mid-instruction: abort immediately, with no write enable asserted on the cycle after the rst edge other than the FETCH decode.
- rst has priority over all transitions and over the counter increment.

Test Plan:
- Reset, then lw (op=6'h23): state sequence 0,1,2,3,4,0. MemWr never 1. RegWr=1 and MemtoReg=1 only in state 4. instr_cnt=1 after.
- subu (op=0, funct=6'h23): EXEC_R shows ALUctr=01, ALUSrcB=00. RWB shows RegWr=1, RegDst=1. Then addu (funct=6'h21): EXEC_R shows ALUctr=00.
- ori (op=6'h0D): ORI_EX shows ALUctr=10, ExtOp=0, ALUSrcB=10. ORI_WB shows RegDst=0. 4 cycles total.
- beq (op=6'h04): with alu_zero=1, state 8 shows PCWr=1, PCSrc=01, ALUctr=01. Repeated with alu_zero=0, PCWr=0. Both runs take 3 cycles.
- Illegal op=6'h3F: in DECODE, illegal=1 and instr_done=1; back in FETCH next cycle. Also sw and j, checking MemWr only in state 5 and PCSrc=10 only in state 9.
- Assert rst during MEMRD of lw: next cycle state=0, RegWr=0, instr_cnt=0. Preload instr_cnt near 2^CNT_W-1 (CNT_W=4 build, 16 instructions) and check it wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control and status bundle between the multi-cycle controller
// (master) and the MIPS-subset datapath (slave).
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             PCWr;
    logic             IorD;
    logic             IRWr;
    logic             MemWr;
    logic             RegWr;
    logic             RegDst;
    logic             MemtoReg;
    logic             ExtOp;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUctr;
    logic [1:0]       PCSrc;
    logic             illegal;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;
    logic [3:0]       state;

    modport master (
        input  op, funct, alu_zero,
        output PCWr, IorD, IRWr, MemWr, RegWr, RegDst, MemtoReg, ExtOp,
               ALUSrcA, ALUSrcB, ALUctr, PCSrc, illegal, instr_done,
               instr_cnt, state
    );

    modport slave (
        output op, funct, alu_zero,
        input  PCWr, IorD, IRWr, MemWr, RegWr, RegDst, MemtoReg, ExtOp,
               ALUSrcA, ALUSrcB, ALUctr, PCSrc, illegal, instr_done,
               instr_cnt, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-subset core. One state per
// cycle; datapath controls are decoded from the current state, while the
// retired-instruction counter and the latched ALU operation are registered.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ORI_EX = 4'd10,
        S_ORI_WB = 4'd11
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    state_t           dec_state_s;
    logic [1:0]       alu_op_r;
    logic [CNT_W-1:0] instr_cnt_r;
    logic             is_subu_s;

    logic       pcwr_s, iord_s, irwr_s, memwr_s, regwr_s, regdst_s;
    logic       memtoreg_s, extop_s, alusrca_s, illegal_s, instr_done_s;
    logic [1:0] alusrcb_s, aluctr_s, pcsrc_s;

    assign is_subu_s = (bus.op == OP_RTYPE) && (bus.funct == FN_SUBU);

    // State register: reset aborts any instruction and returns to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ALU operation for R-type execute, captured while the IR is decoded.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_r <= ALU_ADD;
        end else if (state_r == S_DECODE) begin
            alu_op_r <= is_subu_s ? ALU_SUB : ALU_ADD;
        end else begin
            alu_op_r <= alu_op_r;
        end
    end

    // Retired-instruction counter; illegal instructions count as retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt_r <= '0;
        end else if (instr_done_s) begin
            instr_cnt_r <= instr_cnt_r + CNT_W'(1);
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    // Next-state and control decode; reset forces the FETCH decode so no
    // stale write enable survives into the reset cycle.
    always_comb begin
        pcwr_s       = 1'b0;
        iord_s       = 1'b0;
        irwr_s       = 1'b0;
        memwr_s      = 1'b0;
        regwr_s      = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        extop_s      = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        aluctr_s     = ALU_ADD;
        pcsrc_s      = 2'b00;
        illegal_s    = 1'b0;
        instr_done_s = 1'b0;
        state_nxt_s  = S_FETCH;

        if (rst) begin
            dec_state_s = S_FETCH;
        end else begin
            dec_state_s = state_r;
        end

        case (dec_state_s)
            S_FETCH: begin
                pcwr_s      = 1'b1;
                irwr_s      = 1'b1;
                alusrcb_s   = 2'b01;
                state_nxt_s = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
                extop_s   = 1'b1;
                case (bus.op)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_ORI:       state_nxt_s = S_ORI_EX;
                    OP_BEQ:       state_nxt_s = S_BRANCH;
                    OP_J:         state_nxt_s = S_JUMP;
                    OP_RTYPE: begin
                        if ((bus.funct == FN_ADDU) || (bus.funct == FN_SUBU)) begin
                            state_nxt_s = S_EXEC_R;
                        end else begin
                            illegal_s    = 1'b1;
                            instr_done_s = 1'b1;
                            state_nxt_s  = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_s    = 1'b1;
                        instr_done_s = 1'b1;
                        state_nxt_s  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                extop_s   = 1'b1;
                if (bus.op == OP_LW) begin
                    state_nxt_s = S_MEMRD;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord_s      = 1'b1;
                state_nxt_s = S_MEMWB;
            end
            S_MEMWB: begin
                regwr_s      = 1'b1;
                memtoreg_s   = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                iord_s       = 1'b1;
                memwr_s      = 1'b1;
                instr_done_s = 1'b1;
            end
            S_EXEC_R: begin
                alusrca_s   = 1'b1;
                aluctr_s    = alu_op_r;
                state_nxt_s = S_RWB;
            end
            S_RWB: begin
                regwr_s      = 1'b1;
                regdst_s     = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s    = 1'b1;
                aluctr_s     = ALU_SUB;
                pcsrc_s      = 2'b01;
                pcwr_s       = bus.alu_zero;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pcwr_s       = 1'b1;
                pcsrc_s      = 2'b10;
                instr_done_s = 1'b1;
            end
            S_ORI_EX: begin
                alusrca_s   = 1'b1;
                alusrcb_s   = 2'b10;
                aluctr_s    = ALU_OR;
                state_nxt_s = S_ORI_WB;
            end
            S_ORI_WB: begin
                regwr_s      = 1'b1;
                instr_done_s = 1'b1;
            end
            default: begin
                pcwr_s    = 1'b1;
                irwr_s    = 1'b1;
                alusrcb_s = 2'b01;
                illegal_s = 1'b1;
            end
        endcase
    end

    assign bus.PCWr       = pcwr_s;
    assign bus.IorD       = iord_s;
    assign bus.IRWr       = irwr_s;
    assign bus.MemWr      = memwr_s;
    assign bus.RegWr      = regwr_s;
    assign bus.RegDst     = regdst_s;
    assign bus.MemtoReg   = memtoreg_s;
    assign bus.ExtOp      = extop_s;
    assign bus.ALUSrcA    = alusrca_s;
    assign bus.ALUSrcB    = alusrcb_s;
    assign bus.ALUctr     = aluctr_s;
    assign bus.PCSrc      = pcsrc_s;
    assign bus.illegal    = illegal_s;
    assign bus.instr_done = instr_done_s;
    assign bus.instr_cnt  = instr_cnt_r;
    assign bus.state      = state_r;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized and directed bench for mc_ctrl. Expected behaviour
// comes from per-instruction tables (state sequence and control values for
// each cycle of each instruction) plus an integer retirement counter.
module tb_mc_ctrl;
    localparam int CW = 4;

    localparam int K_LW   = 0;
    localparam int K_SW   = 1;
    localparam int K_ADDU = 2;
    localparam int K_SUBU = 3;
    localparam int K_ORI  = 4;
    localparam int K_BEQ  = 5;
    localparam int K_J    = 6;
    localparam int K_ILL  = 7;

    typedef struct packed {
        logic       pcwr;
        logic       iord;
        logic       irwr;
        logic       memwr;
        logic       regwr;
        logic       regdst;
        logic       memtoreg;
        logic       extop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluctr;
        logic [1:0] pcsrc;
        logic       illegal;
        logic       done;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   model_cnt = 0;

    mc_ctrl_if #(.CNT_W(CW)) bus ();

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observed();
        ctl_t c;
        c.pcwr     = bus.PCWr;
        c.iord     = bus.IorD;
        c.irwr     = bus.IRWr;
        c.memwr    = bus.MemWr;
        c.regwr    = bus.RegWr;
        c.regdst   = bus.RegDst;
        c.memtoreg = bus.MemtoReg;
        c.extop    = bus.ExtOp;
        c.alusrca  = bus.ALUSrcA;
        c.alusrcb  = bus.ALUSrcB;
        c.aluctr   = bus.ALUctr;
        c.pcsrc    = bus.PCSrc;
        c.illegal  = bus.illegal;
        c.done     = bus.instr_done;
        return c;
    endfunction

    function automatic int instr_len(int k);
        case (k)
            K_LW:                   return 5;
            K_SW, K_ADDU, K_SUBU,
            K_ORI:                  return 4;
            K_BEQ, K_J:             return 3;
            default:                return 2;
        endcase
    endfunction

    // Expected state number at a given cycle of a given instruction.
    function automatic logic [3:0] exp_state(int k, int step);
        logic [3:0] s2 [8];
        logic [3:0] s3 [8];
        s2 = '{4'd2, 4'd2, 4'd6, 4'd6, 4'd10, 4'd8, 4'd9, 4'd0};
        s3 = '{4'd3, 4'd5, 4'd7, 4'd7, 4'd11, 4'd0, 4'd0, 4'd0};
        if (step == 0) return 4'd0;
        if (step == 1) return 4'd1;
        if (step == 2) return s2[k];
        if (step == 3) return s3[k];
        return 4'd4;
    endfunction

    // Expected controls at a given cycle of a given instruction.
    function automatic ctl_t exp_ctl(int k, int step, logic z);
        ctl_t c;
        c = '0;
        if (step == 0) begin
            c.pcwr = 1'b1; c.irwr = 1'b1; c.alusrcb = 2'b01;
        end else if (step == 1) begin
            c.alusrcb = 2'b11; c.extop = 1'b1;
            if (k == K_ILL) begin
                c.illegal = 1'b1; c.done = 1'b1;
            end
        end else begin
            case (k)
                K_LW, K_SW: begin
                    if (step == 2) begin
                        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.extop = 1'b1;
                    end else if (step == 3 && k == K_LW) begin
                        c.iord = 1'b1;
                    end else if (step == 3) begin
                        c.iord = 1'b1; c.memwr = 1'b1; c.done = 1'b1;
                    end else begin
                        c.regwr = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1;
                    end
                end
                K_ADDU, K_SUBU: begin
                    if (step == 2) begin
                        c.alusrca = 1'b1;
                        c.aluctr  = (k == K_SUBU) ? 2'b01 : 2'b00;
                    end else begin
                        c.regwr = 1'b1; c.regdst = 1'b1; c.done = 1'b1;
                    end
                end
                K_ORI: begin
                    if (step == 2) begin
                        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluctr = 2'b10;
                    end else begin
                        c.regwr = 1'b1; c.done = 1'b1;
                    end
                end
                K_BEQ: begin
                    c.alusrca = 1'b1; c.aluctr = 2'b01; c.pcsrc = 2'b01;
                    c.pcwr = z; c.done = 1'b1;
                end
                default: begin
                    c.pcwr = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1;
                end
            endcase
        end
        return c;
    endfunction

    function automatic logic legal_op(logic [5:0] o);
        return (o == 6'h00) || (o == 6'h0D) || (o == 6'h23) ||
               (o == 6'h2B) || (o == 6'h04) || (o == 6'h02);
    endfunction

    task automatic set_instr(int k, logic [5:0] ill_op);
        logic [5:0] o;
        logic [5:0] f;
        f = 6'($urandom_range(0, 63));
        case (k)
            K_LW:    o = 6'h23;
            K_SW:    o = 6'h2B;
            K_ADDU:  begin o = 6'h00; f = 6'h21; end
            K_SUBU:  begin o = 6'h00; f = 6'h23; end
            K_ORI:   o = 6'h0D;
            K_BEQ:   o = 6'h04;
            K_J:     o = 6'h02;
            default: begin
                o = ill_op;
                if (o == 6'h00) begin
                    while (f == 6'h21 || f == 6'h23) f = 6'($urandom_range(0, 63));
                end
            end
        endcase
        bus.op    = o;
        bus.funct = f;
    endtask

    // Runs one instruction from FETCH, checking every cycle and the count.
    task automatic run_instr(int k, logic z, logic [5:0] ill_op, string tag);
        ctl_t e;
        set_instr(k, ill_op);
        bus.alu_zero = z;
        for (int step = 0; step < instr_len(k); step++) begin
            @(negedge clk);
            total++;
            if (bus.state !== exp_state(k, step)) begin
                bad++;
                $display("FAIL %s step%0d state: got %0d want %0d", tag, step, bus.state, exp_state(k, step));
            end
            e = exp_ctl(k, step, z);
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL %s step%0d ctl: got %h want %h", tag, step, observed(), e);
            end
            @(posedge clk);
            #1;
        end
        model_cnt = (model_cnt + 1) % (1 << CW);
        total++;
        if (bus.instr_cnt !== CW'(model_cnt)) begin
            bad++;
            $display("FAIL %s instr_cnt: got %0d want %0d", tag, bus.instr_cnt, model_cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (observed() !== exp_ctl(K_LW, 0, 1'b0)) begin
            bad++;
            $display("FAIL reset_decode: got %h want %h", observed(), exp_ctl(K_LW, 0, 1'b0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0;
        total++;
        if (bus.state !== 4'd0 || bus.instr_cnt !== CW'(0)) begin
            bad++;
            $display("FAIL reset_state: got state=%0d cnt=%0d want state=0 cnt=0", bus.state, bus.instr_cnt);
        end
    endtask

    task automatic test_reset();
        bus.op = 6'h00; bus.funct = 6'h00; bus.alu_zero = 1'b0;
        do_reset();
    endtask

    task automatic test_lw();
        run_instr(K_LW, 1'b0, 6'h00, "lw");
    endtask

    task automatic test_r_type();
        run_instr(K_SUBU, 1'b0, 6'h00, "subu");
        run_instr(K_ADDU, 1'b1, 6'h00, "addu");
    endtask

    task automatic test_ori();
        run_instr(K_ORI, 1'b0, 6'h00, "ori");
    endtask

    task automatic test_beq();
        run_instr(K_BEQ, 1'b1, 6'h00, "beq_taken");
        run_instr(K_BEQ, 1'b0, 6'h00, "beq_not_taken");
    endtask

    task automatic test_illegal_sw_j();
        run_instr(K_ILL, 1'b0, 6'h3F, "illegal_3f");
        run_instr(K_SW, 1'b0, 6'h00, "sw");
        run_instr(K_J, 1'b0, 6'h00, "j");
    endtask

    // Reset asserted while lw is in MEMRD must abort before the write-back.
    task automatic test_reset_mid();
        do_reset();
        set_instr(K_LW, 6'h00);
        for (int step = 0; step < 4; step++) begin
            @(negedge clk);
            total++;
            if (bus.state !== exp_state(K_LW, step)) begin
                bad++;
                $display("FAIL rst_mid step%0d state: got %0d want %0d", step, bus.state, exp_state(K_LW, step));
            end
            if (step == 3) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        total++;
        if (bus.state !== 4'd0 || bus.RegWr !== 1'b0 || bus.instr_cnt !== CW'(0)) begin
            bad++;
            $display("FAIL rst_mid_abort: got state=%0d regwr=%0b cnt=%0d want 0 0 0", bus.state, bus.RegWr, bus.instr_cnt);
        end
        rst = 1'b0;
        model_cnt = 0;
        run_instr(K_LW, 1'b0, 6'h00, "lw_after_rst");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) run_instr(K_J, 1'b0, 6'h00, "wrap_j");
        run_instr(K_ILL, 1'b0, 6'h00, "wrap_last");
        total++;
        if (bus.instr_cnt !== CW'(0)) begin
            bad++;
            $display("FAIL wrap: got %0d want 0", bus.instr_cnt);
        end
    endtask

    task automatic test_random();
        int         k;
        logic [5:0] o;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 7);
            o = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) o = 6'h00;
            while (o != 6'h00 && legal_op(o)) o = 6'($urandom_range(0, 63));
            run_instr(k, 1'($urandom_range(0, 1)), o, "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_r_type();
        test_ori();
        test_beq();
        test_illegal_sw_j();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
